// File: rtl/jtkicker_psgwr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtkicker_psgwr_pkg
//  Description : Shared types and defaults for the Kicker PSG write sequencer.
//                The FSM state encoding is common to both channels.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtkicker_psgwr_pkg;

  // Per-channel handshake phases
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } psg_state_t;

  localparam int c_AW_DEF    = 2;   // FIFO address width, depth = 2**AW
  localparam int c_TMO_W_DEF = 10;  // ready-timeout counter width (ti_cen ticks)

endpackage
`default_nettype wire

// File: rtl/jtkicker_psgwr_ch.sv
`default_nettype none
// ============================================================================
//  Module      : jtkicker_psgwr_ch
//  Description : One PSG write channel: byte FIFO plus the cs_n/wr_n
//                handshake FSM aligned to the chip clock enable.
//                Optional ready timeout: JTKICKER_PSGWR_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtkicker_psgwr_ch
  import jtkicker_psgwr_pkg::*;
#(
  parameter int AW    = c_AW_DEF,
  parameter int TMO_W = c_TMO_W_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpu_cen_i,
  input  logic       wr_i,
  input  logic [7:0] din_i,
  input  logic       ti_cen_i,
  input  logic       ti_ready_i,
  output logic       cs_n_o,
  output logic       wr_n_o,
  output logic [7:0] dout_o,
  output logic       busy_o,
  output logic       ovf_o,
  output logic       tmo_o
);

  localparam int c_DEPTH = 1 << AW;

  logic [7:0]    mem_q [c_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          ovf_q;

  psg_state_t    state_q;
  logic          cs_n_q;
  logic          wr_n_q;
  logic [7:0]    dout_q;
  logic          armed_q;   // a ti_cen tick has been seen since entering RELEASE

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_rel_ok;

  assign w_push   = cpu_cen_i & wr_i;
  // The head byte leaves the FIFO only when its strobe ends
  assign w_pop    = (state_q == ST_STROBE) & ti_cen_i;
  assign w_empty  = (cnt_q == '0);
  assign w_full   = (cnt_q == (AW+1)'(c_DEPTH));
  // A full FIFO still accepts a byte when the head leaves on the same edge
  assign w_wr_en  = w_push & (~w_full | w_pop);
  assign w_rel_ok = ti_ready_i & (armed_q | ti_cen_i);

  // Occupancy next-state from push/pop
  always_comb begin
    cnt_d = cnt_q;
    case ({w_wr_en, w_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage; contents are discarded logically by the pointer reset
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wptr_q] <= din_i;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (w_wr_en) wptr_q <= wptr_q + 1'b1;
      if (w_pop)   rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (w_push & w_full & ~w_pop) ovf_q <= 1'b1;
    end
  end

`ifdef JTKICKER_PSGWR_TIMEOUT_EN
  // Value one tick before all-ones: the next not-ready tick expires the wait
  localparam logic [TMO_W-1:0] c_TMO_LAST = ~TMO_W'(1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_q;
  logic             w_tmo_hit;
  assign w_tmo_hit = ti_cen_i & ~ti_ready_i & (tmo_cnt_q == c_TMO_LAST);
  assign tmo_o     = tmo_q;
`else
  // No timeout logic; the flag is constant low for any counter width
  localparam logic c_TMO_OFF = (TMO_W < 0);
  assign tmo_o = c_TMO_OFF;
`endif

  // Handshake FSM with registered chip-side outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      dout_q    <= 8'h00;
      armed_q   <= 1'b0;
`ifdef JTKICKER_PSGWR_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!w_empty) begin
            dout_q  <= mem_q[rptr_q];
            cs_n_q  <= 1'b0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ti_cen_i) begin
            wr_n_q  <= 1'b0;
            state_q <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (ti_cen_i) begin
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            armed_q   <= 1'b0;
`ifdef JTKICKER_PSGWR_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            state_q   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (ti_cen_i) armed_q <= 1'b1;
          if (w_rel_ok) begin
            state_q <= ST_IDLE;
          end
`ifdef JTKICKER_PSGWR_TIMEOUT_EN
          else if (w_tmo_hit) begin
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (ti_cen_i & ~ti_ready_i) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cs_n_o = cs_n_q;
  assign wr_n_o = wr_n_q;
  assign dout_o = dout_q;
  assign busy_o = ~w_empty | (state_q != ST_IDLE);
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/jtkicker_psgwr.sv
`default_nettype none
// ============================================================================
//  Module      : jtkicker_psgwr
//  Description : Write sequencer for the two Kicker SN76489 PSGs. Each chip
//                has an independent FIFO-fed handshake channel.
//                Optional ready timeout: JTKICKER_PSGWR_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtkicker_psgwr
  import jtkicker_psgwr_pkg::*;
#(
  parameter int AW    = c_AW_DEF,
  parameter int TMO_W = c_TMO_W_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpu_cen,
  input  logic       wr1,
  input  logic       wr2,
  input  logic [7:0] din,
  input  logic       ti1_cen,
  input  logic       ti2_cen,
  input  logic       ti1_ready,
  input  logic       ti2_ready,
  output logic       ti1_cs_n,
  output logic       ti1_wr_n,
  output logic [7:0] ti1_dout,
  output logic       ti2_cs_n,
  output logic       ti2_wr_n,
  output logic [7:0] ti2_dout,
  output logic [1:0] busy,
  output logic [1:0] ovf,
  output logic [1:0] tmo
);

  jtkicker_psgwr_ch #(.AW(AW), .TMO_W(TMO_W)) u_ch1 (
    .clk        (clk),
    .rstn       (rstn),
    .cpu_cen_i  (cpu_cen),
    .wr_i       (wr1),
    .din_i      (din),
    .ti_cen_i   (ti1_cen),
    .ti_ready_i (ti1_ready),
    .cs_n_o     (ti1_cs_n),
    .wr_n_o     (ti1_wr_n),
    .dout_o     (ti1_dout),
    .busy_o     (busy[0]),
    .ovf_o      (ovf[0]),
    .tmo_o      (tmo[0])
  );

  jtkicker_psgwr_ch #(.AW(AW), .TMO_W(TMO_W)) u_ch2 (
    .clk        (clk),
    .rstn       (rstn),
    .cpu_cen_i  (cpu_cen),
    .wr_i       (wr2),
    .din_i      (din),
    .ti_cen_i   (ti2_cen),
    .ti_ready_i (ti2_ready),
    .cs_n_o     (ti2_cs_n),
    .wr_n_o     (ti2_wr_n),
    .dout_o     (ti2_dout),
    .busy_o     (busy[1]),
    .ovf_o      (ovf[1]),
    .tmo_o      (tmo[1])
  );

endmodule
`default_nettype wire

// File: tb/tb_jtkicker_psgwr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtkicker_psgwr
//  Description : Self-checking bench for jtkicker_psgwr. A transaction-level
//                model (byte queues and tick counts) is compared against the
//                DUT every cycle, plus directed literal expectations.
//                Honours JTKICKER_PSGWR_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtkicker_psgwr;

  localparam int AW    = 2;
  localparam int TMO_W = 4;
  localparam int DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cpu_cen = 1'b0;
  logic       wr1 = 1'b0;
  logic       wr2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ti1_cen = 1'b0;
  logic       ti2_cen = 1'b0;
  logic       ti1_ready = 1'b1;
  logic       ti2_ready = 1'b1;
  logic       ti1_cs_n, ti1_wr_n, ti2_cs_n, ti2_wr_n;
  logic [7:0] ti1_dout, ti2_dout;
  logic [1:0] busy, ovf, tmo;

  jtkicker_psgwr #(.AW(AW), .TMO_W(TMO_W)) dut (
    .clk(clk), .rstn(rstn), .cpu_cen(cpu_cen), .wr1(wr1), .wr2(wr2), .din(din),
    .ti1_cen(ti1_cen), .ti2_cen(ti2_cen), .ti1_ready(ti1_ready), .ti2_ready(ti2_ready),
    .ti1_cs_n(ti1_cs_n), .ti1_wr_n(ti1_wr_n), .ti1_dout(ti1_dout),
    .ti2_cs_n(ti2_cs_n), .ti2_wr_n(ti2_wr_n), .ti2_dout(ti2_dout),
    .busy(busy), .ovf(ovf), .tmo(tmo)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  bit cmp_en = 1'b0;

  // Chip clock enables: one pulse every divN clocks, changed on the falling edge
  int div1 = 4, div2 = 5;
  int c1 = 0, c2 = 0;
  initial forever begin
    @(negedge clk);
    c1 = (c1 + 1 >= div1) ? 0 : c1 + 1;
    c2 = (c2 + 1 >= div2) ? 0 : c2 + 1;
    ti1_cen = (c1 == 0);
    ti2_cen = (c2 == 0);
  end

  // ---------------- transaction-level model ----------------
  // m_tk counts chip ticks since the byte was presented:
  // 0 = select only, 1 = strobing, >=2 = released (3 once a tick was seen there)
  logic [7:0] mq [2][$];
  bit         m_pres [2];
  int         m_tk   [2];
  int         m_low  [2];
  bit         m_ovf  [2];
  bit         m_tmo  [2];
  logic [7:0] m_dout [2];

  task automatic model_step(input int n, input logic w, input logic cen, input logic rdy);
    int sz0;
    bit pop;
    if (!rstn) begin
      mq[n].delete();
      m_pres[n] = 0; m_tk[n] = 0; m_low[n] = 0;
      m_ovf[n] = 0; m_tmo[n] = 0; m_dout[n] = 8'h00;
      return;
    end
    sz0 = mq[n].size();
    pop = 0;
    if (!m_pres[n]) begin
      if (sz0 > 0) begin
        m_pres[n] = 1; m_tk[n] = 0; m_low[n] = 0; m_dout[n] = mq[n][0];
      end
    end else if (m_tk[n] < 2) begin
      if (cen) begin
        m_tk[n]++;
        if (m_tk[n] == 2) pop = 1;
      end
    end else begin
      if (rdy && (m_tk[n] == 3 || cen)) m_pres[n] = 0;
`ifdef JTKICKER_PSGWR_TIMEOUT_EN
      else if (cen && !rdy) begin
        m_low[n]++;
        if (m_low[n] == (1 << TMO_W) - 1) begin
          m_tmo[n] = 1; m_pres[n] = 0;
        end
      end
`endif
      if (cen) m_tk[n] = 3;
    end
    if (pop) void'(mq[n].pop_front());
    if (cpu_cen && w) begin
      if (sz0 < DEPTH || pop) mq[n].push_back(din);
      else m_ovf[n] = 1;
    end
  endtask

  function automatic logic [12:0] model_out(input int n);
    logic cs_n, wr_n, bsy;
    cs_n = !(m_pres[n] && m_tk[n] < 2);
    wr_n = !(m_pres[n] && m_tk[n] == 1);
    bsy  = (mq[n].size() > 0) || m_pres[n];
    return {cs_n, wr_n, m_dout[n], bsy, m_ovf[n], m_tmo[n]};
  endfunction

  initial forever begin
    @(posedge clk);
    model_step(0, wr1, ti1_cen, ti1_ready);
    model_step(1, wr2, ti2_cen, ti2_ready);
  end

  // Every-cycle comparison against the model
  initial forever begin
    logic [12:0] a, e;
    @(negedge clk);
    if (cmp_en) begin
      for (int n = 0; n < 2; n++) begin
        a = (n == 0) ? {ti1_cs_n, ti1_wr_n, ti1_dout, busy[0], ovf[0], tmo[0]}
                     : {ti2_cs_n, ti2_wr_n, ti2_dout, busy[1], ovf[1], tmo[1]};
        e = model_out(n);
        checks++;
        if (a !== e) begin
          errors++;
          if (nprint < 20) begin
            $display("FAIL model_ch%0d t=%0t got %h want %h (cs,wr,dout,busy,ovf,tmo)", n + 1, $time, a, e);
            nprint++;
          end
        end
      end
    end
  end

  // Capture the byte on each falling wr_n
  logic [7:0] cap1[$], cap2[$];
  logic p1 = 1'b1, p2 = 1'b1;
  initial forever begin
    @(negedge clk);
    if (p1 === 1'b1 && ti1_wr_n === 1'b0) cap1.push_back(ti1_dout);
    if (p2 === 1'b1 && ti2_wr_n === 1'b0) cap2.push_back(ti2_dout);
    p1 = ti1_wr_n;
    p2 = ti2_wr_n;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit cond(input int c);
    case (c)
      0:       return ti1_wr_n == 1'b0;
      1:       return ti1_wr_n == 1'b1;
      2:       return busy == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int c, input int maxc, input string name);
    int k;
    k = 0;
    while (!cond(c) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (!cond(c)) begin
      checks++;
      errors++;
      $display("FAIL %s timeout after %0d cycles", name, maxc);
    end
  endtask

  task automatic wait_ticks1(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (ti1_cen) k++;
    end
  endtask

  task automatic push(input logic w1, input logic w2, input logic [7:0] d);
    @(negedge clk);
    cpu_cen = 1'b1; wr1 = w1; wr2 = w2; din = d;
    @(negedge clk);
    cpu_cen = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int wl, cl, k;
    bit idle2;

    // 1. reset for 3 clocks
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_cs_n", {ti2_cs_n, ti1_cs_n}, 2'b11);
    chk("rst_wr_n", {ti2_wr_n, ti1_wr_n}, 2'b11);
    chk("rst_busy", busy, 2'b00);
    chk("rst_ovf",  ovf,  2'b00);
    chk("rst_tmo",  tmo,  2'b00);
    chk("rst_dout", {ti2_dout, ti1_dout}, 16'h0000);
    rstn = 1'b1;

    // 2. single byte on PSG1
    div1 = 4; div2 = 5;
    cap1.delete(); cap2.delete();
    push(1'b1, 1'b0, 8'h9F);
    wl = 0; cl = 0; k = 0; idle2 = 1;
    do begin
      @(negedge clk);
      if (ti1_wr_n === 1'b0) wl++;
      if (ti1_cs_n === 1'b0) cl++;
      if (ti2_cs_n !== 1'b1 || ti2_wr_n !== 1'b1) idle2 = 0;
      k++;
    end while (busy[0] && k < 200);
    chk("t2_dout", ti1_dout, 8'h9F);
    chk("t2_wr_low_clks", wl, 4);
    chk("t2_cs_low_5to8", (cl >= 5 && cl <= 8), 1);
    chk("t2_psg2_idle", idle2, 1);
    chk("t2_busy_done", busy, 2'b00);
    chk("t2_cap", (cap1.size() == 1) ? cap1[0] : 8'hxx, 8'h9F);

    // Strobe without cpu_cen is ignored
    @(negedge clk); wr1 = 1'b1; cpu_cen = 1'b0; din = 8'h11;
    @(negedge clk); wr1 = 1'b0;
    @(negedge clk);
    chk("nocen_busy", busy, 2'b00);

    // 3. overflow with ready held low
    ti1_ready = 1'b0;
    cap1.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_cen = 1'b1; wr1 = 1'b1; din = 8'hA0 + i[7:0];
    end
    @(negedge clk); cpu_cen = 1'b0; wr1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_ovf", ovf, 2'b01);
    repeat (6) @(negedge clk);
    ti1_ready = 1'b1;
    wait_for(2, 400, "t3_drain");
    chk("t3_count", cap1.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order%0d", i), (cap1.size() > i) ? cap1[i] : 8'hxx, 8'hA0 + i[7:0]);

    // 4. both channels at different rates
    div1 = 3; div2 = 7;
    cap1.delete(); cap2.delete();
    push(1'b1, 1'b0, 8'h80);
    push(1'b0, 1'b1, 8'h90);
    push(1'b1, 1'b1, 8'h33);
    wait_for(2, 400, "t4_drain");
    chk("t4_ch1_n", cap1.size(), 2);
    chk("t4_ch2_n", cap2.size(), 2);
    chk("t4_ch1_b0", (cap1.size() > 0) ? cap1[0] : 8'hxx, 8'h80);
    chk("t4_ch1_b1", (cap1.size() > 1) ? cap1[1] : 8'hxx, 8'h33);
    chk("t4_ch2_b0", (cap2.size() > 0) ? cap2[0] : 8'hxx, 8'h90);
    chk("t4_ch2_b1", (cap2.size() > 1) ? cap2[1] : 8'hxx, 8'h33);
    div1 = 4; div2 = 5;

`ifndef JTKICKER_PSGWR_TIMEOUT_EN
    // 5. long ready stall holds RELEASE; release, then next byte follows
    ti1_ready = 1'b0;
    push(1'b1, 1'b0, 8'hA5);
    push(1'b1, 1'b0, 8'h5A);
    wait_for(0, 100, "t5_strobe");
    wait_for(1, 100, "t5_release");
    wait_ticks1(50);
    @(negedge clk);
    chk("t5_hold_cs", ti1_cs_n, 1'b1);
    chk("t5_hold_dout", ti1_dout, 8'hA5);
    chk("t5_hold_busy", busy[0], 1'b1);
    ti1_ready = 1'b1;
    @(negedge clk);
    chk("t5_idle_cs", ti1_cs_n, 1'b1);
    @(negedge clk);
    chk("t5_setup_cs", ti1_cs_n, 1'b0);
    chk("t5_setup_dout", ti1_dout, 8'h5A);
    wait_for(2, 400, "t5_drain");
`endif

    // 6. ready stuck low
    ti1_ready = 1'b0;
    push(1'b1, 1'b0, 8'hC3);
    wait_for(0, 100, "t6_strobe");
    wait_for(1, 100, "t6_release");
    wait_ticks1(14);
    @(negedge clk);
    chk("t6_tmo_before", tmo, 2'b00);
    wait_ticks1(1);
    @(negedge clk);
`ifdef JTKICKER_PSGWR_TIMEOUT_EN
    chk("t6_tmo_set", tmo, 2'b01);
    chk("t6_idle_busy", busy[0], 1'b0);
`else
    chk("t6_tmo_zero", tmo, 2'b00);
    wait_ticks1(20);
    @(negedge clk);
    chk("t6_still_busy", busy[0], 1'b1);
    chk("t6_still_cs", ti1_cs_n, 1'b1);
`endif
    ti1_ready = 1'b1;
    wait_for(2, 400, "t6_drain");

    // 1b. reset pulse in the middle of a strobe
    push(1'b1, 1'b0, 8'h77);
    wait_for(0, 100, "t1b_strobe");
    rstn = 1'b0;
    @(negedge clk);
    chk("t1b_cs_n", ti1_cs_n, 1'b1);
    chk("t1b_wr_n", ti1_wr_n, 1'b1);
    chk("t1b_busy", busy, 2'b00);
    chk("t1b_ovf",  ovf,  2'b00);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t1b_no_resume", busy, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
